// File: rtl/lcd_pclk_gen.sv
// Programmable LCD pixel-clock generator: divides clk by a runtime ratio N
// and emits a registered pixel clock plus rise/fall strobes for clock-enable use.
module lcd_pclk_gen #(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_DIV  = 2,
    parameter int MAX_DIV      = 255,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             lcd_pclk,
    output logic             pclk_rise,
    output logic             pclk_fall,
    output logic             locked,
    output logic [DIV_W-1:0] cur_div
);

    localparam int LK_W = $clog2(LOCK_PERIODS + 1);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] pend_div, pend_div_nxt;
    logic             pend, pend_nxt;
    logic [LK_W-1:0]  lock_cnt, lock_nxt;
    logic             pclk_nxt, err_nxt;
    logic             take, legal, period_end;

    // A pending ratio blocks further offers until it is applied at the boundary.
    assign cfg_ready  = ~pend;
    assign take       = cfg_valid && cfg_ready;
    assign legal      = (cfg_div >= DIV_W'(2)) && (cfg_div <= DIV_W'(MAX_DIV));
    assign period_end = (state == RUN) && (cnt == cur_div - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (period_end && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt      = cnt;
        div_nxt      = cur_div;
        pend_nxt     = pend;
        pend_div_nxt = pend_div;
        lock_nxt     = lock_cnt;
        err_nxt      = 1'b0;

        if (take) begin
            if (!legal) begin
                err_nxt = 1'b1;
            end else if (state == IDLE) begin
                div_nxt  = cfg_div;
                lock_nxt = '0;
            end else begin
                pend_nxt     = 1'b1;
                pend_div_nxt = cfg_div;
            end
        end

        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                lock_nxt = '0;
            end
            RUN: begin
                if (period_end) begin
                    cnt_nxt = '0;
                    if (pend) begin
                        div_nxt  = pend_div;
                        pend_nxt = 1'b0;
                        lock_nxt = '0;
                    end else if (state_nxt == IDLE) begin
                        lock_nxt = '0;
                    end else if (lock_cnt != LK_W'(LOCK_PERIODS)) begin
                        lock_nxt = lock_cnt + LK_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: cnt_nxt = '0;
        endcase

        // High phase occupies the first N>>1 counts of each period.
        pclk_nxt = (state_nxt == RUN) && (cnt_nxt < (div_nxt >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cur_div   <= DIV_W'(DEFAULT_DIV);
            pend      <= 1'b0;
            pend_div  <= '0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            lcd_pclk  <= 1'b0;
            pclk_rise <= 1'b0;
            pclk_fall <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            cur_div   <= div_nxt;
            pend      <= pend_nxt;
            pend_div  <= pend_div_nxt;
            lock_cnt  <= lock_nxt;
            locked    <= (lock_nxt == LK_W'(LOCK_PERIODS));
            lcd_pclk  <= pclk_nxt;
            pclk_rise <= pclk_nxt & ~lcd_pclk;
            pclk_fall <= ~pclk_nxt & lcd_pclk;
            cfg_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_pclk_gen.sv
// Bench for lcd_pclk_gen: directed per-cycle vectors feed an expected queue,
// a monitor compares the DUT outputs after every clock edge.
module tb_lcd_pclk_gen;

    localparam int DIV_W = 9;
    localparam int W     = 6 + DIV_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             lcd_pclk;
    logic             pclk_rise;
    logic             pclk_fall;
    logic             locked;
    logic [DIV_W-1:0] cur_div;

    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    lcd_pclk_gen #(
        .DIV_W(DIV_W),
        .DEFAULT_DIV(2),
        .MAX_DIV(255),
        .LOCK_PERIODS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .cfg_valid(cfg_valid),
        .cfg_div(cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err(cfg_err),
        .lcd_pclk(lcd_pclk),
        .pclk_rise(pclk_rise),
        .pclk_fall(pclk_fall),
        .locked(locked),
        .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    assign obs = {lcd_pclk, pclk_rise, pclk_fall, locked, cfg_ready, cfg_err, cur_div};

    function automatic logic pat(input string s, input int i);
        return (s.len() == 1) ? (s[0] == "1") : (s[i] == "1");
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pclk,rise,fall,lock,rdy,err=%b div=%0d, want %b div=%0d",
                     name, act[W-1:DIV_W], act[DIV_W-1:0], exp[W-1:DIV_W], exp[DIV_W-1:0]);
        end
    endtask

    // One string character per clock edge, leftmost first; "0"/"1" means constant.
    task automatic seq(input string name, input string en, input string vld,
                       input logic [DIV_W-1:0] din,
                       input string pclk, input string rise, input string fall,
                       input string lock, input string rdy, input string err,
                       input logic [DIV_W-1:0] div0, input logic [DIV_W-1:0] div1,
                       input int sw);
        int n;
        n = pclk.len();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable    = pat(en, i);
            cfg_valid = pat(vld, i);
            cfg_div   = din;
            exp_q.push_back({pat(pclk, i), pat(rise, i), pat(fall, i), pat(lock, i),
                             pat(rdy, i), pat(err, i), (i < sw) ? div0 : div1});
            name_q.push_back(name);
        end
    endtask

    initial begin
        logic [W-1:0] e;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, obs, e);
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        #1 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hold", obs, {6'b000010, 9'd2});
        rst_n = 1'b1;

        // N=2 from reset, lock after two periods, stop at boundary
        seq("n2_run", "1111111100", "0", 9'd0, "1010101000", "1010101000", "0101010100",
            "0000111100", "1", "0", 9'd2, 9'd2, 99);

        // N=5 loaded in IDLE then run: 11000 repeating
        seq("n5_run", "01111111111111110", "10000000000000000", 9'd5,
            "01100011000110000", "01000010000100000", "00010000100001000",
            "00000000000111110", "1", "0", 9'd5, 9'd5, 99);

        // N=4 running, offer 6 at cnt=1, applied at the next boundary
        seq("n4_load", "0", "1", 9'd4, "0", "0", "0", "0", "1", "0", 9'd4, 9'd4, 99);
        seq("n4_to_n6", "1111111111111111111111111111110",
            "0000000000100000000000000000000", 9'd6,
            "1100110011001110001110001110000",
            "1000100010001000001000001000000",
            "0010001000100001000001000001000",
            "0000000011110000000000001111110",
            "1111111111001111111111111111111", "0", 9'd4, 9'd6, 12);

        // illegal ratios while running at N=6
        seq("err_div1", "111111", "100000", 9'd1, "111000", "100000", "000100",
            "0", "1", "100000", 9'd6, 9'd6, 99);
        seq("err_div0", "111111", "100000", 9'd0, "111000", "100000", "000100",
            "0", "1", "100000", 9'd6, 9'd6, 99);
        seq("err_div256", "1111110", "1000000", 9'd256, "1110000", "1000000", "0001000",
            "1111110", "1", "1000000", 9'd6, 9'd6, 99);

        // N=8: enable dropped at cnt=2 finishes the period; re-raise at cnt=6 is seamless
        seq("n8_load", "0", "1", 9'd8, "0", "0", "0", "0", "1", "0", 9'd8, 9'd8, 99);
        seq("n8_drop", "1110000000", "0", 9'd8, "1111000000", "1000000000", "0000100000",
            "0", "1", "0", 9'd8, 9'd8, 99);
        seq("n8_reraise", "11100001111111110", "0", 9'd8, "11110000111100000",
            "10000000100000000", "00001000000010000", "0", "1", "0", 9'd8, 9'd8, 99);

        // N=6 high phase with a pending ratio, then asynchronous reset
        seq("n6_load", "0", "1", 9'd6, "0", "0", "0", "0", "1", "0", 9'd6, 9'd6, 99);
        seq("n6_pend", "11", "01", 9'd3, "11", "10", "0", "0", "10", "0", 9'd6, 9'd6, 99);
        @(posedge clk);
        #3;
        chk("pre_reset_high", obs, {6'b100000, 9'd6});
        rst_n     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("reset_mid", obs, {6'b000010, 9'd2});
        @(negedge clk);
        rst_n = 1'b1;

        // pending ratio must be gone: plain N=2 afterwards
        seq("post_rst", "1111110", "0", 9'd0, "1010100", "1010100", "0101010",
            "0000110", "1", "0", 9'd2, 9'd2, 99);

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_pclk_gen.md
Name: lcd_pclk_gen

Overview:
- Runtime-programmable LCD pixel-clock generator. Replaces fixed /2 and /4 taps with an N-divider loaded over a valid/ready config port.
- Ratio changes are glitch-free: they are applied only at a period boundary.
- Outputs are a registered divided clock plus single-cycle rise/fall strobes, so downstream timing logic can run on clk with clock enables.
- Sits between the panel-ID decoder and the LCD timing driver.

Parameters:
- DIV_W, 8: width of the divide-ratio field and period counter.
- DEFAULT_DIV, 2: ratio loaded at reset. Must satisfy 2 <= DEFAULT_DIV <= MAX_DIV.
- MAX_DIV, 255: largest legal ratio. Must be <= 2^DIV_W - 1.
- LOCK_PERIODS, 2: number of complete periods at the current ratio before locked asserts (>= 1).

Ports:
- clk, input, 1: system clock, 50 MHz nominal.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: run request for the pixel clock.
- cfg_valid, input, 1: new ratio offered.
- cfg_div, input, DIV_W: requested divide ratio N.
- cfg_ready, output, 1: block can accept a ratio.
- cfg_err, output, 1: one-cycle pulse when an offered ratio is rejected.
- lcd_pclk, output, 1: divided pixel clock, registered.
- pclk_rise, output, 1: high in the cycle lcd_pclk goes 0->1.
- pclk_fall, output, 1: high in the cycle lcd_pclk goes 1->0.
- locked, output, 1: ratio stable for LOCK_PERIODS periods.
- cur_div, output, DIV_W: ratio currently in effect.

Behaviour:
- Reset: rst_n is asynchronous, active-low; the block is clocked on clk.
  - Outputs: lcd_pclk=0, pclk_rise=0, pclk_fall=0, locked=0, cfg_err=0, cfg_ready=1, cur_div=DEFAULT_DIV.
  - State: state=IDLE, cnt=0, lock counter=0, pending flag=0.
  - Reset asserted mid-operation forces these values immediately, including lcd_pclk=0. It does not wait for a period boundary.
- Waveform for ratio N:
  - High phase H = N>>1 cycles, low phase = N-H cycles. N=4 gives 1100; N=5 gives 11000.
  - cnt runs 0..N-1 and wraps to 0.
  - lcd_pclk, pclk_rise and pclk_fall are all registered from the next-state cnt, so they change on the same edge.
- States:
  - IDLE: lcd_pclk=0, cnt held at 0.
    - On an edge sampling enable=1: go to RUN, cnt=0, lcd_pclk=1, pclk_rise=1 on that same edge. Latency from enable sampled to first rise is 0 edges.
  - RUN: cnt advances every cycle.
    - At the end of a period (cnt==N-1, lcd_pclk low):
      - If a ratio is pending: load it into cur_div, start the new period at cnt=0 with lcd_pclk=1, clear the lock counter, and set cfg_ready=1 on the next edge.
      - If enable=0: go to IDLE. lcd_pclk stays 0 and no rise occurs.
      - If both hold: load the ratio, then go to IDLE.
  - enable dropping mid-period never truncates a high or low phase. If enable returns to 1 before the period ends, RUN continues seamlessly.
- Config handshake: a transfer occurs on an edge where cfg_valid and cfg_ready are both 1.
  - Illegal ratio (cfg_div < 2 or > MAX_DIV): cfg_err=1 for one cycle, cfg_div ignored, cfg_ready stays 1, cur_div unchanged.
  - Legal ratio in IDLE: cur_div is loaded on the accepting edge, cfg_ready stays 1, locked=0.
  - Legal ratio in RUN: latched as pending, cfg_ready=0 until the load edge. Offers made while cfg_ready=0 are not consumed and raise no error.
  - Accepting a ratio equal to cur_div still waits for the boundary and still resets lock.
- locked:
  - The lock counter increments at each completed period in RUN.
  - locked=1 once the count reaches LOCK_PERIODS. The counter saturates there.
  - Cleared on any ratio load, on entry to IDLE, and by reset.
- cnt compares use DIV_W bits. There is no overflow, because N-1 <= MAX_DIV-1.

Test Plan:
- Reset, then enable=1 with DEFAULT_DIV=2 -> lcd_pclk toggles 1,0,1,0 from the first sampled edge. pclk_rise fires every 2 cycles. locked=1 after 2 periods (4 cycles).
- In IDLE, cfg_div=5 accepted, then enable=1 -> repeating pattern 1,1,0,0,0. pclk_rise at cycles 0,5,10; pclk_fall at cycles 2,7. cur_div=5.
- While running at N=4, offer cfg_div=6 at cnt=1 -> cfg_ready=0. The current 1100 period completes untruncated, then 111000 begins at the boundary. locked drops, then returns after 2 periods of 6. cfg_ready returns to 1.
- Offer cfg_div=1, then cfg_div=0, then MAX_DIV+1 (with DIV_W=9) -> cfg_err pulses each time. cur_div and the waveform are unchanged. cfg_ready stays 1.
- At N=8, drop enable at cnt=2 -> lcd_pclk finishes its high phase and low phase, then stays 0 in IDLE. Separately, re-raise enable at cnt=6 -> no gap in the period sequence.
- Assert rst_n=0 while lcd_pclk=1 at N=6 -> lcd_pclk=0 asynchronously, cur_div=DEFAULT_DIV, locked=0, a pending ratio is discarded, and cfg_ready=1.
